// File: rtl/rst_seq.sv
// Reset sequencer for the S1D13700 core: filters the external reset pin, holds reset,
// releases bus/core/display domains in staggered order, then drives the pixel clock enable.
module rst_seq #(
  parameter int FILT_CYC  = 4,
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_CYC = 8,
  parameter int DIV       = 4
) (
  input  logic       P_MCLK,
  input  logic       P_RST,
  input  logic       P_RSTX_PIN,
  input  logic       P_SOFT_RST,
  output logic       P_BUS_RST,
  output logic       P_CORE_RST,
  output logic       P_DISP_RST,
  output logic       P_READY,
  output logic       P_PCLK_EN,
  output logic [7:0] P_RST_CNT
);

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_REL_BUS  = 2'd1,
    ST_REL_CORE = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  localparam logic [15:0] FILT_LAST  = 16'(FILT_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] STAGE_LAST = 16'(STAGE_CYC - 1);
  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);

  logic        r_s1;
  logic        r_s2;
  logic        r_filt;
  logic [15:0] r_fcnt;
  state_t      r_state;
  logic [15:0] r_hold;
  logic [15:0] r_stage;
  logic [15:0] r_div;
  logic        r_bus_rst;
  logic        r_core_rst;
  logic        r_disp_rst;
  logic        r_ready;
  logic        r_pclk_en;
  logic [7:0]  r_rst_cnt;
  logic        w_req;

  // A pin level is accepted only after it has persisted FILT_CYC synced cycles.
  always_ff @(posedge P_MCLK) begin
    if (P_RST) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_filt <= 1'b1;
      r_fcnt <= 16'd0;
    end else begin
      r_s1 <= P_RSTX_PIN;
      r_s2 <= r_s1;
      if (r_s2 != r_filt) begin
        if (r_fcnt == FILT_LAST) begin
          r_filt <= r_s2;
          r_fcnt <= 16'd0;
        end else begin
          r_fcnt <= r_fcnt + 16'd1;
        end
      end else begin
        r_fcnt <= 16'd0;
      end
    end
  end

  assign w_req = ~r_filt | P_SOFT_RST;

  // Sequencer FSM with registered domain resets, ready flag, pixel enable and event count.
  always_ff @(posedge P_MCLK) begin
    if (P_RST) begin
      r_state    <= ST_ASSERT;
      r_hold     <= 16'd0;
      r_stage    <= 16'd0;
      r_div      <= 16'd0;
      r_bus_rst  <= 1'b1;
      r_core_rst <= 1'b1;
      r_disp_rst <= 1'b1;
      r_ready    <= 1'b0;
      r_pclk_en  <= 1'b0;
      r_rst_cnt  <= 8'd0;
    end else if (w_req && (r_state != ST_ASSERT)) begin
      // Any request after release restarts the whole sequence and counts once.
      r_state    <= ST_ASSERT;
      r_hold     <= 16'd0;
      r_stage    <= 16'd0;
      r_div      <= 16'd0;
      r_bus_rst  <= 1'b1;
      r_core_rst <= 1'b1;
      r_disp_rst <= 1'b1;
      r_ready    <= 1'b0;
      r_pclk_en  <= 1'b0;
      if (r_rst_cnt != 8'hFF) begin
        r_rst_cnt <= r_rst_cnt + 8'd1;
      end else begin
        r_rst_cnt <= r_rst_cnt;
      end
    end else begin
      case (r_state)
        ST_ASSERT: begin
          r_div     <= 16'd0;
          r_pclk_en <= 1'b0;
          r_stage   <= 16'd0;
          if (w_req) begin
            r_hold <= 16'd0;
          end else if (r_hold == HOLD_LAST) begin
            r_hold    <= 16'd0;
            r_state   <= ST_REL_BUS;
            r_bus_rst <= 1'b0;
          end else begin
            r_hold <= r_hold + 16'd1;
          end
        end
        ST_REL_BUS: begin
          r_div     <= 16'd0;
          r_pclk_en <= 1'b0;
          if (r_stage == STAGE_LAST) begin
            r_stage    <= 16'd0;
            r_state    <= ST_REL_CORE;
            r_core_rst <= 1'b0;
          end else begin
            r_stage <= r_stage + 16'd1;
          end
        end
        ST_REL_CORE: begin
          r_div     <= 16'd0;
          r_pclk_en <= 1'b0;
          if (r_stage == STAGE_LAST) begin
            r_stage    <= 16'd0;
            r_state    <= ST_RUN;
            r_disp_rst <= 1'b0;
            r_ready    <= 1'b1;
          end else begin
            r_stage <= r_stage + 16'd1;
          end
        end
        ST_RUN: begin
          // Enable fires on the DIV-th edge after RUN entry, then every DIV edges.
          if (r_div == DIV_LAST) begin
            r_div     <= 16'd0;
            r_pclk_en <= 1'b1;
          end else begin
            r_div     <= r_div + 16'd1;
            r_pclk_en <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_ASSERT;
          r_hold     <= 16'd0;
          r_stage    <= 16'd0;
          r_div      <= 16'd0;
          r_bus_rst  <= 1'b1;
          r_core_rst <= 1'b1;
          r_disp_rst <= 1'b1;
          r_ready    <= 1'b0;
          r_pclk_en  <= 1'b0;
        end
      endcase
    end
  end

  assign P_BUS_RST  = r_bus_rst;
  assign P_CORE_RST = r_core_rst;
  assign P_DISP_RST = r_disp_rst;
  assign P_READY    = r_ready;
  assign P_PCLK_EN  = r_pclk_en;
  assign P_RST_CNT  = r_rst_cnt;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default build plus a DIV=1 build sharing the same inputs.
module tb_rst_seq;

  logic       P_MCLK;
  logic       P_RST;
  logic       P_RSTX_PIN;
  logic       P_SOFT_RST;
  logic       P_BUS_RST, P_CORE_RST, P_DISP_RST, P_READY, P_PCLK_EN;
  logic [7:0] P_RST_CNT;
  logic       d1_bus_rst, d1_core_rst, d1_disp_rst, d1_ready, d1_pclk_en;
  logic [7:0] d1_rst_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  rst_seq dut (
    .P_MCLK(P_MCLK), .P_RST(P_RST), .P_RSTX_PIN(P_RSTX_PIN), .P_SOFT_RST(P_SOFT_RST),
    .P_BUS_RST(P_BUS_RST), .P_CORE_RST(P_CORE_RST), .P_DISP_RST(P_DISP_RST),
    .P_READY(P_READY), .P_PCLK_EN(P_PCLK_EN), .P_RST_CNT(P_RST_CNT)
  );

  rst_seq #(.DIV(1)) dut_div1 (
    .P_MCLK(P_MCLK), .P_RST(P_RST), .P_RSTX_PIN(P_RSTX_PIN), .P_SOFT_RST(P_SOFT_RST),
    .P_BUS_RST(d1_bus_rst), .P_CORE_RST(d1_core_rst), .P_DISP_RST(d1_disp_rst),
    .P_READY(d1_ready), .P_PCLK_EN(d1_pclk_en), .P_RST_CNT(d1_rst_cnt)
  );

  initial P_MCLK = 1'b0;
  always #5 P_MCLK = ~P_MCLK;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge P_MCLK);
    #1;
  endtask

  // Edge e counts from the last edge that saw a request (or P_RST) as edge 0.
  task automatic run_seq(input int n);
    for (int e = 1; e <= n; e++) begin
      step();
      chk("bus_rst",  int'(P_BUS_RST),  int'(e < 16));
      chk("core_rst", int'(P_CORE_RST), int'(e < 24));
      chk("disp_rst", int'(P_DISP_RST), int'(e < 32));
      chk("ready",    int'(P_READY),    int'(e >= 32));
      chk("pclk_en",  int'(P_PCLK_EN),  int'((e >= 36) && (((e - 36) % 4) == 0)));
      chk("pclk_div1", int'(d1_pclk_en), int'(e >= 33));
      chk("rst_cnt",  int'(P_RST_CNT),  exp_cnt);
    end
  endtask

  task automatic soft_pulse();
    P_SOFT_RST = 1'b1;
    step();
    P_SOFT_RST = 1'b0;
    if (exp_cnt < 255) exp_cnt++;
    chk("soft_bus",   int'(P_BUS_RST),  1);
    chk("soft_core",  int'(P_CORE_RST), 1);
    chk("soft_disp",  int'(P_DISP_RST), 1);
    chk("soft_ready", int'(P_READY),    0);
    chk("soft_pclk",  int'(P_PCLK_EN),  0);
    chk("soft_cnt",   int'(P_RST_CNT),  exp_cnt);
  endtask

  initial begin
    P_RST = 1'b1;
    P_RSTX_PIN = 1'b1;
    P_SOFT_RST = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_bus",   int'(P_BUS_RST),  1);
    chk("rst_core",  int'(P_CORE_RST), 1);
    chk("rst_disp",  int'(P_DISP_RST), 1);
    chk("rst_ready", int'(P_READY),    0);
    chk("rst_pclk",  int'(P_PCLK_EN),  0);
    chk("rst_cnt",   int'(P_RST_CNT),  0);
    chk("rst_pclk1", int'(d1_pclk_en), 0);

    // Power-on sequence 16/24/32, pixel enable at 36, 40, 44.
    P_RST = 1'b0;
    run_seq(44);

    // Short pin glitch is filtered out.
    P_RSTX_PIN = 1'b0;
    for (int k = 0; k < 3; k++) step();
    P_RSTX_PIN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("glitch_bus",   int'(P_BUS_RST), 0);
      chk("glitch_ready", int'(P_READY),   1);
    end
    chk("glitch_cnt", int'(P_RST_CNT), exp_cnt);

    // Long pin low: resets at edge 7, bus release 22 edges after the rise.
    P_RSTX_PIN = 1'b0;
    exp_cnt++;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 6) chk("pin_ready_before", int'(P_READY), 1);
      if (k == 7) begin
        chk("pin_bus",   int'(P_BUS_RST),  1);
        chk("pin_core",  int'(P_CORE_RST), 1);
        chk("pin_ready", int'(P_READY),    0);
        chk("pin_cnt",   int'(P_RST_CNT),  exp_cnt);
      end
    end
    P_RSTX_PIN = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      step();
      if (k == 21) chk("rise_bus_held",  int'(P_BUS_RST),  1);
      if (k == 22) chk("rise_bus_rel",   int'(P_BUS_RST),  0);
      if (k == 29) chk("rise_core_held", int'(P_CORE_RST), 1);
      if (k == 30) chk("rise_core_rel",  int'(P_CORE_RST), 0);
      if (k == 37) chk("rise_ready_lo",  int'(P_READY),    0);
      if (k == 38) chk("rise_ready_hi",  int'(P_READY),    1);
    end
    chk("rise_cnt", int'(P_RST_CNT), exp_cnt);

    // Soft pulse in RUN, then again during REL_CORE.
    soft_pulse();
    run_seq(26);
    soft_pulse();
    run_seq(36);

    // Coincident pin and soft request count once.
    P_RSTX_PIN = 1'b0;
    P_SOFT_RST = 1'b1;
    step();
    P_SOFT_RST = 1'b0;
    exp_cnt++;
    chk("coin_bus", int'(P_BUS_RST), 1);
    chk("coin_cnt", int'(P_RST_CNT), exp_cnt);
    for (int k = 0; k < 9; k++) step();
    P_RSTX_PIN = 1'b1;
    for (int k = 0; k < 40; k++) step();
    chk("coin_ready",   int'(P_READY),   1);
    chk("coin_cnt_end", int'(P_RST_CNT), exp_cnt);

    // Counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      soft_pulse();
      for (int k = 0; k < 32; k++) step();
      chk("sat_ready", int'(P_READY), 1);
    end
    chk("sat_cnt", int'(P_RST_CNT), 255);

    // P_RST mid-sequence clears everything, uncounted.
    soft_pulse();
    for (int k = 0; k < 20; k++) step();
    chk("mid_bus_rel", int'(P_BUS_RST), 0);
    P_RST = 1'b1;
    step();
    exp_cnt = 0;
    chk("mid_bus",   int'(P_BUS_RST),  1);
    chk("mid_core",  int'(P_CORE_RST), 1);
    chk("mid_disp",  int'(P_DISP_RST), 1);
    chk("mid_ready", int'(P_READY),    0);
    chk("mid_cnt",   int'(P_RST_CNT),  0);
    P_RST = 1'b0;
    run_seq(44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
